// File: rtl/lvt_pkg.sv
// Shared types and sizing helpers for the live-value-table multiport RAM.
package lvt_pkg;

  // Clear sequencer states.
  typedef enum logic [0:0] {
    StClear,
    StReady
  } lvt_state_e;

  // Bits needed to name a write port; never below one so the LVT always exists.
  function automatic int unsigned lvt_width(input int unsigned ports);
    return (ports <= 2) ? 1 : $clog2(ports);
  endfunction

  // Bits needed to address a memory of the given depth; never below one.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/simple_dual_port_ram.sv
// One write port, one synchronous read port, read-first on address collision.
module simple_dual_port_ram
  import lvt_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = addr_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage array; no reset, contents are initialised by the owner.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read register; non-blocking read of mem_q gives old data on same-address write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lvt_multiport_ram.sv
// Multiport RAM built from WRITE_PORTS x READ_PORTS 1W1R banks plus a live-value
// table recording which write port last wrote each address.
module lvt_multiport_ram
  import lvt_pkg::*;
#(
  parameter int unsigned      WRITE_PORTS = 4,
  parameter int unsigned      READ_PORTS  = 8,
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      DEPTH       = 1024,
  parameter logic [WIDTH-1:0] INIT_VALUE  = '0,
  localparam int unsigned     AW          = addr_width(DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst,
  output logic                                init_busy,
  input  logic [WRITE_PORTS-1:0][AW-1:0]      waddr,
  input  logic [WRITE_PORTS-1:0]              wen,
  input  logic [WRITE_PORTS-1:0][WIDTH-1:0]   wdata,
  input  logic [READ_PORTS-1:0][AW-1:0]       raddr,
  input  logic [READ_PORTS-1:0]               ren,
  output logic [READ_PORTS-1:0][WIDTH-1:0]    rdata,
  output logic [READ_PORTS-1:0]               rvalid
);

  localparam int unsigned LVT_W = lvt_width(WRITE_PORTS);

  lvt_state_e                           state_q;
  logic [AW-1:0]                        cnt_q;
  logic                                 clearing;
  logic [LVT_W-1:0]                     lvt_q [DEPTH];
  logic [READ_PORTS-1:0][LVT_W-1:0]     sel_q;
  logic [READ_PORTS-1:0]                rvalid_q;
  logic [WRITE_PORTS-1:0]               bank_we;
  logic [WRITE_PORTS-1:0][AW-1:0]       bank_waddr;
  logic [WRITE_PORTS-1:0][WIDTH-1:0]    bank_wdata;
  logic [WIDTH-1:0]                     bank_rdata [WRITE_PORTS][READ_PORTS];

  assign clearing  = (state_q == StClear);
  assign init_busy = clearing;
  assign rvalid    = rvalid_q;

  // Clear sequencer: one address per cycle, state itself is the done flag so no wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else if (state_q == StClear) begin
      if (cnt_q == AW'(DEPTH - 1)) begin
        state_q <= StReady;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Bank write muxing: the clear sequence owns bank row 0, user writes are dropped.
  always_comb begin
    bank_we    = '0;
    bank_waddr = '0;
    bank_wdata = '0;
    for (int w = 0; w < WRITE_PORTS; w++) begin
      if (clearing) begin
        bank_we[w]    = (w == 0);
        bank_waddr[w] = cnt_q;
        bank_wdata[w] = INIT_VALUE;
      end else begin
        bank_we[w]    = wen[w];
        bank_waddr[w] = waddr[w];
        bank_wdata[w] = wdata[w];
      end
    end
  end

  // LVT update; later loop iterations override earlier ones, so the highest port wins.
  always_ff @(posedge clk) begin
    if (clearing) begin
      lvt_q[cnt_q] <= '0;
    end else begin
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (wen[w]) lvt_q[waddr[w]] <= LVT_W'(w);
      end
    end
  end

  // LVT read and valid pipeline, aligned with the one-cycle bank read.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= '0;
      rvalid_q <= '0;
    end else begin
      for (int r = 0; r < READ_PORTS; r++) begin
        rvalid_q[r] <= ren[r] & ~clearing;
        if (ren[r]) sel_q[r] <= lvt_q[raddr[r]];
      end
    end
  end

  for (genvar gw = 0; gw < WRITE_PORTS; gw++) begin : g_wr
    for (genvar gr = 0; gr < READ_PORTS; gr++) begin : g_rd
      simple_dual_port_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_bank (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (bank_we[gw]),
        .waddr_i (bank_waddr[gw]),
        .wdata_i (bank_wdata[gw]),
        .re_i    (ren[gr]),
        .raddr_i (raddr[gr]),
        .rdata_o (bank_rdata[gw][gr])
      );
    end
  end

  // Output select: each read port takes the bank the LVT named for its address.
  always_comb begin
    rdata = '0;
    for (int r = 0; r < READ_PORTS; r++) begin
      rdata[r] = bank_rdata[sel_q[r]][r];
    end
  end

endmodule

// File: tb/tb_lvt_multiport_ram.sv
// Scoreboard bench for lvt_multiport_ram: the driver queues expected read data per
// read port, the negedge monitor pops and compares whenever a response is due.
module tb_lvt_multiport_ram;

  localparam int unsigned WP = 4;
  localparam int unsigned RP = 8;
  localparam int unsigned W  = 32;
  localparam int unsigned D  = 1024;
  localparam int unsigned AW = 10;

  typedef struct {
    logic [W-1:0] data;
    int unsigned  due;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      init_busy;
  logic [WP-1:0][AW-1:0]     waddr;
  logic [WP-1:0]             wen;
  logic [WP-1:0][W-1:0]      wdata;
  logic [RP-1:0][AW-1:0]     raddr;
  logic [RP-1:0]             ren;
  logic [RP-1:0][W-1:0]      rdata;
  logic [RP-1:0]             rvalid;

  int unsigned cyc    = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          mon_en = 1'b0;
  exp_t        q [RP][$];
  logic [W-1:0] mdl [D];

  lvt_multiport_ram #(
    .WRITE_PORTS (WP),
    .READ_PORTS  (RP),
    .WIDTH       (W),
    .DEPTH       (D),
    .INIT_VALUE  ('0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy),
    .waddr     (waddr),
    .wen       (wen),
    .wdata     (wdata),
    .raddr     (raddr),
    .ren       (ren),
    .rdata     (rdata),
    .rvalid    (rvalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a due expectation must show up as rvalid with matching data, else rvalid low.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      for (int r = 0; r < RP; r++) begin
        checks++;
        if (q[r].size() != 0 && q[r][0].due == cyc) begin
          e = q[r].pop_front();
          if (rvalid[r] !== 1'b1 || rdata[r] !== e.data) begin
            errors++;
            $display("FAIL read port %0d cycle %0d: got rvalid=%b rdata=%h, want rvalid=1 rdata=%h",
                     r, cyc, rvalid[r], rdata[r], e.data);
          end
        end else if (rvalid[r] !== 1'b0) begin
          errors++;
          $display("FAIL spurious rvalid port %0d cycle %0d: got rvalid=%b, want 0",
                   r, cyc, rvalid[r]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic expect_rd(input int r, input logic [W-1:0] v);
    exp_t e;
    e.data = v;
    e.due  = cyc + 1;
    q[r].push_back(e);
  endtask

  // Advance one cycle; with mdl_on the model supplies read-first expectations and
  // applies writes in ascending port order so the highest port wins.
  task automatic step(input bit mdl_on);
    if (mdl_on) begin
      for (int r = 0; r < RP; r++) if (ren[r]) expect_rd(r, mdl[raddr[r]]);
      for (int w = 0; w < WP; w++) if (wen[w]) mdl[waddr[w]] = wdata[w];
    end
    @(posedge clk);
    #1;
    wen = '0;
    ren = '0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int unsigned a;
    a = $urandom_range(0, 15);
    return (a < 8) ? AW'(a) : AW'(1008 + a);
  endfunction

  initial begin
    int n;
    logic [AW-1:0] init_addrs [RP];
    init_addrs = '{10'd0, 10'd1023, 10'd5, 10'd9, 10'd7, 10'd3, 10'd512, 10'd100};
    rst = 1'b1; wen = '0; ren = '0; waddr = '0; wdata = '0; raddr = '0;
    for (int i = 0; i < D; i++) mdl[i] = '0;
    step(0);
    step(0);
    check("reset init_busy", 256'(init_busy), 256'(1'b1));
    check("reset rvalid", 256'(rvalid), 256'(0));
    check("reset rdata", 256'(rdata), 256'(0));
    mon_en = 1'b1;

    // Full clear after reset.
    rst = 1'b0;
    n = 0;
    while (init_busy === 1'b1 && n < 2000) begin
      step(0);
      n++;
    end
    check("clear length", 256'(n), 256'(1024));

    // Cleared contents, including both address extremes.
    for (int r = 0; r < RP; r++) begin
      ren[r] = 1'b1; raddr[r] = init_addrs[r]; expect_rd(r, 32'h0);
    end
    step(0);

    // Single-port write then broadcast read.
    wen[2] = 1'b1; waddr[2] = 10'd5; wdata[2] = 32'hDEADBEEF;
    step(0);
    for (int r = 0; r < RP; r++) begin
      ren[r] = 1'b1; raddr[r] = 10'd5; expect_rd(r, 32'hDEADBEEF);
    end
    step(0);

    // Collision: ports 0, 1, 3 hit address 9, port 3 must win.
    wen[0] = 1'b1; waddr[0] = 10'd9; wdata[0] = 32'h11;
    wen[1] = 1'b1; waddr[1] = 10'd9; wdata[1] = 32'h22;
    wen[3] = 1'b1; waddr[3] = 10'd9; wdata[3] = 32'h44;
    step(0);
    ren[3] = 1'b1; raddr[3] = 10'd9; expect_rd(3, 32'h44);
    step(0);
    wen[0] = 1'b1; waddr[0] = 10'd9; wdata[0] = 32'h55;
    step(0);
    ren[6] = 1'b1; raddr[6] = 10'd9; expect_rd(6, 32'h55);
    step(0);

    // Read-during-write returns old data, then new data the cycle after.
    wen[0] = 1'b1; waddr[0] = 10'd7; wdata[0] = 32'hA;
    step(0);
    wen[1] = 1'b1; waddr[1] = 10'd7; wdata[1] = 32'hB;
    ren[4] = 1'b1; raddr[4] = 10'd7; expect_rd(4, 32'hA);
    step(0);
    ren[4] = 1'b1; raddr[4] = 10'd7; expect_rd(4, 32'hB);
    step(0);
    step(0);
    check("rdata hold", 256'(rdata[4]), 256'(32'hB));

    // Reset part-way through a clear; a write and a read during CLEAR are ignored.
    rst = 1'b1;
    step(0);
    rst = 1'b0;
    repeat (500) step(0);
    rst = 1'b1;
    step(0);
    rst = 1'b0;
    n = 0;
    while (init_busy === 1'b1 && n < 2000) begin
      if (n == 10) begin
        wen[0] = 1'b1; waddr[0] = 10'd3; wdata[0] = 32'hFF;
      end
      if (n == 20) begin
        ren[2] = 1'b1; raddr[2] = 10'd5;
      end
      step(0);
      n++;
    end
    check("restarted clear length", 256'(n), 256'(1024));
    ren[0] = 1'b1; raddr[0] = 10'd3; expect_rd(0, 32'h0);
    ren[1] = 1'b1; raddr[1] = 10'd9; expect_rd(1, 32'h0);
    step(0);

    // Random soak against the reference model, addresses clustered to force collisions.
    for (int i = 0; i < D; i++) mdl[i] = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int w = 0; w < WP; w++) begin
        wen[w]   = ($urandom_range(0, 9) < 4);
        waddr[w] = rand_addr();
        wdata[w] = $urandom;
      end
      for (int r = 0; r < RP; r++) begin
        ren[r]   = ($urandom_range(0, 1) == 1);
        raddr[r] = rand_addr();
      end
      step(1);
    end
    step(0);
    step(0);
    for (int r = 0; r < RP; r++) check("drained queue", 256'(q[r].size()), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
